debounce_edge_detector: RTL and testbench

- Upstream conditioning stage for raw board buttons: per-channel 2-flop synchronizer, sampled saturating debounce and rising-edge pulse generation.
- Produces a clean debounced level and a single-cycle "pressed" pulse per channel.
- The pulse drives counter/register enables directly, e.g. increment/decrement/reset of the 4-bit LED counter.
- One sample-tick counter is shared by all channels to save area.

---
 rtl/debounce_pkg.sv | 30 +++
 rtl/debounce_edge_detector_sync.sv | 42 ++++
 rtl/debounce_edge_detector.sv | 180 ++++++++++++++++++
 tb/tb_debounce_edge_detector.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
//   Shared constants and helpers for the button conditioning block.
//   - Default sample / press / repeat counts derived from CLOCK_FREQ:
//     500 us sample period, 100 ms press qualification, 200 ms auto-repeat.
//   - cnt_width(): width of a counter that must hold values 0..n-1,
//     never narrower than one bit.
//   No ports (package only).
// -----------------------------------------------------------------------------
package debounce_pkg;

  localparam int CLOCK_FREQ       = 125_000_000;
  localparam int SAMPLE_PERIOD_US = 500;
  localparam int PRESS_TIME_MS    = 100;
  localparam int REPEAT_TIME_MS   = 200;

  // 62500 clocks per sample at 125 MHz
  localparam int DEF_SAMPLE_CNT_MAX = (CLOCK_FREQ / 1_000_000) * SAMPLE_PERIOD_US;
  // 200 samples of 500 us = 100 ms
  localparam int DEF_PULSE_CNT_MAX  = (PRESS_TIME_MS * 1000) / SAMPLE_PERIOD_US;
  // 400 samples of 500 us = 200 ms
  localparam int DEF_REPEAT_CNT_MAX = (REPEAT_TIME_MS * 1000) / SAMPLE_PERIOD_US;

  // Bits needed to count 0..n-1; a 1-state counter still gets one bit so
  // that no zero-width vectors are ever declared.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_edge_detector_sync.sv
// -----------------------------------------------------------------------------
// debounce_edge_detector_sync
//   Two-flop synchronizer bank for asynchronous button inputs.
//   Output lags the raw input by two clock cycles.
//
//   Parameters:
//     WIDTH   number of independent bits
//   Ports:
//     clk     system clock, rising edge
//     rst_n   asynchronous active-low reset, clears both flop stages
//     raw     asynchronous inputs
//     synced  inputs resynchronised to clk
// -----------------------------------------------------------------------------
module debounce_edge_detector_sync
  import debounce_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] synced
);

  logic [WIDTH-1:0] meta_p0;
  logic [WIDTH-1:0] sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      // stage 0: may go metastable, never used directly
      meta_p0 <= raw;
      // stage 1: settled copy
      sync_p1 <= meta_p0;
    end
  end

  assign synced = sync_p1;

endmodule

// File: rtl/debounce_edge_detector.sv
// -----------------------------------------------------------------------------
// debounce_edge_detector
//   Per-channel button conditioning: 2-flop synchronizer, sampled saturating
//   debounce and a one-cycle "pressed" pulse on each qualified press.
//   A single sample-tick counter is shared by all channels.
//
//   Optional feature (compile-time macro DEBOUNCE_AUTO_REPEAT_EN):
//     while a channel is held, an extra out_pulse is emitted every
//     REPEAT_CNT_MAX sample ticks after the initial press pulse.
//
//   Parameters:
//     WIDTH           number of channels
//     SAMPLE_CNT_MAX  clocks per sample tick (>= 2)
//     PULSE_CNT_MAX   consecutive high samples that qualify a press (>= 1)
//     REPEAT_CNT_MAX  sample ticks between auto-repeat pulses (>= 1)
//   Ports:
//     clk        system clock, rising edge
//     rst_n      asynchronous active-low reset
//     in         raw asynchronous button inputs, active-high
//     out_level  debounced level per channel
//     out_pulse  one-cycle pulse per qualified press (and repeat)
// -----------------------------------------------------------------------------
module debounce_edge_detector
  import debounce_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int SAMPLE_CNT_MAX = DEF_SAMPLE_CNT_MAX,
  parameter int PULSE_CNT_MAX  = DEF_PULSE_CNT_MAX,
  parameter int REPEAT_CNT_MAX = DEF_REPEAT_CNT_MAX
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out_level,
  output logic [WIDTH-1:0] out_pulse
);

  localparam int SW = cnt_width(SAMPLE_CNT_MAX);
  localparam int PW = cnt_width(PULSE_CNT_MAX + 1);

  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_CNT_MAX - 1);
  localparam logic [PW-1:0] PULSE_MAX   = PW'(PULSE_CNT_MAX);

  // Elaboration-time guard on parameter ranges.
  if (SAMPLE_CNT_MAX < 2) begin : g_bad_sample_cnt
    $error("SAMPLE_CNT_MAX must be at least 2");
  end
  if (PULSE_CNT_MAX < 1) begin : g_bad_pulse_cnt
    $error("PULSE_CNT_MAX must be at least 1");
  end
  if (REPEAT_CNT_MAX < 1) begin : g_bad_repeat_cnt
    $error("REPEAT_CNT_MAX must be at least 1");
  end

  // Saturating increment of a qualification counter.
  function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] v);
    return (v == PULSE_MAX) ? v : v + 1'b1;
  endfunction

  logic [WIDTH-1:0] in_sync;
  logic [SW-1:0]    sample_cnt;
  logic             sample_tick;
  logic [PW-1:0]    cnt      [WIDTH];
  logic [PW-1:0]    cnt_next [WIDTH];
  logic [WIDTH-1:0] qualified;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] pulse_next;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] pulse;

  // stage: synchronizer
  debounce_edge_detector_sync #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (in),
    .synced (in_sync)
  );

  // stage: shared sample tick
  assign sample_tick = (sample_cnt == SAMPLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
    end else if (sample_tick) begin
      sample_cnt <= '0;
    end else begin
      sample_cnt <= sample_cnt + 1'b1;
    end
  end

  // stage: per-channel qualification counters
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = cnt[i];
      if (sample_tick) begin
        cnt_next[i] = in_sync[i] ? sat_inc(cnt[i]) : '0;
      end
      qualified[i] = (cnt_next[i] == PULSE_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  // The level register is loaded from the next counter value so that it
  // moves on the same edge as the counter, one cycle after the tick.
  // Between ticks qualified equals level, so press can only fire on a tick.
  assign press = qualified & ~level;

`ifdef DEBOUNCE_AUTO_REPEAT_EN
  localparam int RW = cnt_width(REPEAT_CNT_MAX);
  localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_CNT_MAX - 1);

  logic [RW-1:0]    rep      [WIDTH];
  logic [RW-1:0]    rep_next [WIDTH];
  logic [WIDTH-1:0] rep_fire;

  // stage: auto-repeat counters, running only while the level is held
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      rep_next[i] = rep[i];
      rep_fire[i] = 1'b0;
      if (!level[i]) begin
        rep_next[i] = '0;
      end else if (sample_tick && qualified[i]) begin
        // a tick that samples low ends the hold instead of repeating
        if (rep[i] == REPEAT_LAST) begin
          rep_next[i] = '0;
          rep_fire[i] = 1'b1;
        end else begin
          rep_next[i] = rep[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        rep[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        rep[i] <= rep_next[i];
      end
    end
  end

  assign pulse_next = press | rep_fire;
`else
  assign pulse_next = press;
`endif

  // stage: registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
      pulse <= '0;
    end else begin
      level <= qualified;
      pulse <= pulse_next;
    end
  end

  assign out_level = level;
  assign out_pulse = pulse;

endmodule

// File: tb/tb_debounce_edge_detector.sv
// -----------------------------------------------------------------------------
// tb_debounce_edge_detector
//   Scoreboard bench for debounce_edge_detector with WIDTH=4,
//   SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, REPEAT_CNT_MAX=2.
//   The reference model tracks, per channel, the run length of consecutive
//   high samples taken at every sample tick; a press is the tick on which
//   the run length reaches PULSE_CNT_MAX (plus, with auto-repeat, every
//   REPEAT_CNT_MAX further ticks). Expected pulses are queued by edge number
//   and a separate monitor pops them whenever out_pulse is non-zero.
// -----------------------------------------------------------------------------
module tb_debounce_edge_detector;

  localparam int WIDTH = 4;
  localparam int S     = 4;
  localparam int P     = 3;
  localparam int R     = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in = '0;
  logic [WIDTH-1:0] out_level;
  logic [WIDTH-1:0] out_pulse;

  always #5 clk = ~clk;

  debounce_edge_detector #(
    .WIDTH          (WIDTH),
    .SAMPLE_CNT_MAX (S),
    .PULSE_CNT_MAX  (P),
    .REPEAT_CNT_MAX (R)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .out_level (out_level),
    .out_pulse (out_pulse)
  );

  typedef struct {
    int               cyc;
    logic [WIDTH-1:0] mask;
  } ev_t;

  ev_t              exp_q[$];
  int               n_checks = 0;
  int               n_fail   = 0;
  int               n_pulses = 0;
  int               edge_no  = 0;
  int               runlen[WIDTH];
  logic [WIDTH-1:0] exp_level = '0;
  // input values seen at the previous two clock edges
  logic [WIDTH-1:0] seen1 = '0;
  logic [WIDTH-1:0] seen2 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d, t=%0t)", name, act, exp, edge_no, $time);
    end
  endtask

  // Reference model: one pass per clock edge since reset release.
  initial begin
    for (int i = 0; i < WIDTH; i++) runlen[i] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        edge_no   = 0;
        exp_level = '0;
        seen1     = '0;
        seen2     = '0;
        for (int i = 0; i < WIDTH; i++) runlen[i] = 0;
        exp_q.delete();
      end else begin
        logic [WIDTH-1:0] smp;
        logic [WIDTH-1:0] pm;
        edge_no++;
        smp   = seen2;          // the raw input two edges ago
        seen2 = seen1;
        seen1 = in;
        if (edge_no % S == 0) begin
          pm = '0;
          for (int i = 0; i < WIDTH; i++) begin
            runlen[i] = smp[i] ? runlen[i] + 1 : 0;
            if (runlen[i] == P) pm[i] = 1'b1;
`ifdef DEBOUNCE_AUTO_REPEAT_EN
            if (runlen[i] > P && ((runlen[i] - P) % R) == 0) pm[i] = 1'b1;
`endif
            exp_level[i] = (runlen[i] >= P);
          end
          if (pm != '0) exp_q.push_back('{cyc: edge_no, mask: pm});
        end
      end
    end
  end

  // Monitor: compares outputs half a cycle after each edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < edge_no) begin
          n_checks++;
          n_fail++;
          $display("FAIL missed_pulse: got none, expected mask %0h at edge %0d", exp_q[0].mask, exp_q[0].cyc);
          void'(exp_q.pop_front());
        end
        check("out_level", 32'(out_level), 32'(exp_level));
        if (out_pulse != '0) begin
          n_pulses++;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse: got mask %0h at edge %0d, expected no pulse", out_pulse, edge_no);
          end else begin
            ev_t ev;
            ev = exp_q.pop_front();
            check("pulse_edge", 32'(edge_no), 32'(ev.cyc));
            check("pulse_mask", 32'(out_pulse), 32'(ev.mask));
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse(input int n);
    rst_n = 1'b0;
    #1;
    check("rst_async_level", 32'(out_level), 32'd0);
    check("rst_async_pulse", 32'(out_pulse), 32'd0);
    cycles(n);
    rst_n = 1'b1;
  endtask

  initial begin
    // reset state
    cycles(3);
    check("reset_level", 32'(out_level), 32'd0);
    check("reset_pulse", 32'(out_pulse), 32'd0);
    rst_n = 1'b1;

    // clean press on channel 0
    in[0] = 1'b1;
    cycles(40);
    check("held_level0", 32'(out_level[0]), 32'd1);

    // bouncing channel 1, then stable high
    for (int k = 0; k < 10; k++) begin
      in[1] = ~in[1];
      cycles(3);
    end
    in[1] = 1'b1;
    cycles(30);

    // release and re-press channel 0
    in[0] = 1'b0;
    cycles(8);
    check("released_level0", 32'(out_level[0]), 32'd0);
    in[0] = 1'b1;
    cycles(30);

    // simultaneous press on all channels
    in = '0;
    cycles(20);
    in = '1;
    cycles(30);

    // reset while channel 2 is held and qualified
    check("pre_reset_level2", 32'(out_level[2]), 32'd1);
    reset_pulse(3);
    cycles(30);

    // randomized activity with occasional resets
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ($urandom_range(0, 15) == 0) in[i] = ~in[i];
      end
      cycles(1);
      if ($urandom_range(0, 499) == 0) reset_pulse(int'($urandom_range(1, 3)));
    end

    // drain
    in = '0;
    cycles(20);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("some_pulses_seen", 32'(n_pulses >= 5), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
